// File: rtl/parking_occupancy_display.sv
// Parking occupancy counter with a two-digit multiplexed 7-segment display.
// Optional overflow/underflow alarm: enabled by defining PARKING_OVERFLOW_ALARM_EN.
module parking_occupancy_display #(
    parameter int unsigned CAPACITY     = 15,
    parameter int unsigned REFRESH_DIV  = 4,
    parameter int unsigned ALARM_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s,
    input  logic       r,
    output logic [6:0] count,
    output logic       full,
    output logic       empty,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       alarm
);

    localparam logic [6:0] CAP      = 7'(CAPACITY);
    localparam logic [7:0] REF_LAST = 8'(REFRESH_DIV - 1);

    logic [6:0] r_count;
    logic [7:0] r_refresh;
    logic [1:0] r_an;

    logic       w_inc;
    logic       w_dec;
    logic       w_viol;
    logic [3:0] w_tens;
    logic [3:0] w_units;
    logic [6:0] w_tens_x10;

    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b0111111;
            4'd1:    p = 7'b0000110;
            4'd2:    p = 7'b1011011;
            4'd3:    p = 7'b1001111;
            4'd4:    p = 7'b1100110;
            4'd5:    p = 7'b1101101;
            4'd6:    p = 7'b1111101;
            4'd7:    p = 7'b0000111;
            4'd8:    p = 7'b1111111;
            4'd9:    p = 7'b1101111;
            default: p = 7'b0000000;
        endcase
        return p;
    endfunction

    // Simultaneous s and r cancel each other and are never a violation.
    assign w_inc  = s & ~r & (r_count != CAP);
    assign w_dec  = r & ~s & (r_count != 7'd0);
    assign w_viol = (s & ~r & (r_count == CAP)) | (r & ~s & (r_count == 7'd0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= 7'd0;
        end else if (w_inc) begin
            r_count <= r_count + 7'd1;
        end else if (w_dec) begin
            r_count <= r_count - 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_refresh <= 8'd0;
            r_an      <= 2'b01;
        end else if (r_refresh == REF_LAST) begin
            r_refresh <= 8'd0;
            r_an      <= {r_an[0], r_an[1]};
        end else begin
            r_refresh <= r_refresh + 8'd1;
        end
    end

    // Tens by threshold compare (count <= 99), units by subtraction.
    always_comb begin
        w_tens = 4'd0;
        for (int i = 1; i <= 9; i++) begin
            if (r_count >= 7'(10 * i)) begin
                w_tens = 4'(i);
            end
        end
    end

    assign w_tens_x10 = 7'(w_tens) * 7'd10;
    assign w_units    = 4'(r_count - w_tens_x10);

    always_comb begin
        if (!rst_n) begin
            seg = seg_pattern(4'd0);
        end else if (r_an == 2'b10) begin
            seg = (w_tens == 4'd0) ? 7'b0000000 : seg_pattern(w_tens);
        end else begin
            seg = seg_pattern(w_units);
        end
    end

    assign count = r_count;
    assign an    = r_an;
    assign full  = rst_n & (r_count == CAP);
    assign empty = ~rst_n | (r_count == 7'd0);

`ifdef PARKING_OVERFLOW_ALARM_EN
    localparam logic [15:0] ALARM_LEN = 16'(ALARM_CYCLES);

    logic [15:0] r_alarm_timer;
    logic        r_alarm;

    // Timer holds the remaining high cycles including the current one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alarm_timer <= 16'd0;
            r_alarm       <= 1'b0;
        end else if (w_viol) begin
            r_alarm_timer <= ALARM_LEN;
            r_alarm       <= 1'b1;
        end else if (r_alarm_timer != 16'd0) begin
            r_alarm_timer <= r_alarm_timer - 16'd1;
            r_alarm       <= (r_alarm_timer != 16'd1);
        end else begin
            r_alarm       <= 1'b0;
        end
    end

    assign alarm = r_alarm;
`else
    logic w_unused_viol;
    assign w_unused_viol = w_viol;
    assign alarm         = 1'b0;
`endif

endmodule
